// File: rtl/riscv_periph_arbiter.sv
// Two-master round-robin arbiter sharing one req/gnt/rvalid peripheral slave; one transaction in flight.
// Latency: grant is combinational with the request; response is combinational from s_rvalid (no added cycle).
// Backpressure: s_gnt=0 holds off grants; masters keep req stable until granted; nothing is buffered here.
module riscv_periph_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   // master 0: core data port
   input  logic                m0_req,
   input  logic                m0_wren,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic                m0_gnt,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_rerr,
   // master 1: debug / DMA port
   input  logic                m1_req,
   input  logic                m1_wren,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_gnt,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_rerr,
   // shared slave port
   output logic                s_req,
   output logic                s_wren,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_gnt,
   input  logic                s_rvalid,
   input  logic [DATA_W-1:0]   s_rdata
);

   // Bundled request fields so the winner mux is a single select.
   typedef struct packed {
      logic                wren;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   wdata;
      logic [DATA_W/8-1:0] wstrb;
   } req_t;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Counter only needs to reach TIMEOUT-1; keep at least one bit so a disabled timeout still elaborates.
   localparam int          TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit          TO_EN = (TIMEOUT != 0);
   localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   logic [0:0]    state;
   logic          owner;     // master that owns the outstanding transaction
   logic          rr_last;   // last master granted; loses the next tie
   logic [TW-1:0] tcnt;      // cycles spent waiting for s_rvalid

   req_t          m0_r;
   req_t          m1_r;
   req_t          win_r;
   logic          winner;
   logic          busy;
   logic          rsp_ok;
   logic          rsp_to;
   logic          rsp_done;
   logic          can_issue;
   logic          hs;

   assign m0_r = '{wren: m0_wren, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
   assign m1_r = '{wren: m1_wren, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

   assign busy     = (state == ST_BUSY);
   assign rsp_ok   = busy & s_rvalid;
   // A real response in the deadline cycle wins over the timeout.
   assign rsp_to   = busy & ~s_rvalid & TO_EN & (tcnt == TLAST);
   assign rsp_done = rsp_ok | rsp_to;
   // Completing response and next grant share a cycle, giving back-to-back throughput.
   assign can_issue = ~busy | rsp_done;

   // Round-robin pick: a lone requester wins, a tie goes to the master not granted last.
   always_comb begin
      winner = 1'b0;
      if (m0_req & m1_req) begin
         winner = ~rr_last;
      end else if (m1_req) begin
         winner = 1'b1;
      end
      win_r = winner ? m1_r : m0_r;
   end

   assign s_req   = can_issue & (m0_req | m1_req) & ~rst;
   assign hs      = s_req & s_gnt;

   assign s_wren  = s_req ? win_r.wren  : 1'b0;
   assign s_addr  = s_req ? win_r.addr  : '0;
   assign s_wdata = s_req ? win_r.wdata : '0;
   assign s_wstrb = s_req ? win_r.wstrb : '0;

   assign m0_gnt  = hs & ~winner;
   assign m1_gnt  = hs &  winner;

   // Responses steer only to the owner; reset masks anything still in flight.
   assign m0_rvalid = rsp_done & ~owner & ~rst;
   assign m1_rvalid = rsp_done &  owner & ~rst;
   assign m0_rerr   = rsp_to   & ~owner & ~rst;
   assign m1_rerr   = rsp_to   &  owner & ~rst;
   assign m0_rdata  = (rsp_ok & ~owner & ~rst) ? s_rdata : '0;
   assign m1_rdata  = (rsp_ok &  owner & ~rst) ? s_rdata : '0;

   // Transaction tracking: new handshake takes priority over returning to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         owner   <= 1'b0;
         rr_last <= 1'b1;
         tcnt    <= '0;
      end else if (hs) begin
         state   <= ST_BUSY;
         owner   <= winner;
         rr_last <= winner;
         tcnt    <= '0;
      end else if (rsp_done) begin
         state   <= ST_IDLE;
         tcnt    <= '0;
      end else if (busy && (tcnt != TLAST)) begin
         tcnt    <= tcnt + TW'(1);
      end
   end

endmodule

// File: tb/tb_riscv_periph_arbiter.sv
// Directed bench for riscv_periph_arbiter with a hand-driven slave.
// Latency: inputs change 1ns after posedge, outputs sampled 1ns later.
// Backpressure: s_gnt is driven directly per step to exercise stalls.
module tb_riscv_periph_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 64;
   localparam int TIMEOUT = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                m0_req, m0_wren, m0_gnt, m0_rvalid, m0_rerr;
   logic [ADDR_W-1:0]   m0_addr;
   logic [DATA_W-1:0]   m0_wdata, m0_rdata;
   logic [DATA_W/8-1:0] m0_wstrb;
   logic                m1_req, m1_wren, m1_gnt, m1_rvalid, m1_rerr;
   logic [ADDR_W-1:0]   m1_addr;
   logic [DATA_W-1:0]   m1_wdata, m1_rdata;
   logic [DATA_W/8-1:0] m1_wstrb;
   logic                s_req, s_wren, s_gnt, s_rvalid;
   logic [ADDR_W-1:0]   s_addr;
   logic [DATA_W-1:0]   s_wdata, s_rdata;
   logic [DATA_W/8-1:0] s_wstrb;

   int n_assert = 0;
   int n_fail   = 0;

   riscv_periph_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wren(m0_wren), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
      .m1_req(m1_req), .m1_wren(m1_wren), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
      .s_req(s_req), .s_wren(s_wren), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and land 1ns after the edge, ready to drive.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic quiet();
      m0_req = 0; m0_wren = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_req = 0; m1_wren = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      s_gnt = 1; s_rvalid = 0; s_rdata = '0;
   endtask

   initial begin
      // ---- reset: outputs forced quiet even with request and stray response present
      quiet();
      rst = 1; m0_req = 1; m0_addr = 32'h10; s_rvalid = 1; s_rdata = 64'hDEAD;
      step(); settle();
      check("rst_s_req",     s_req,     0);
      check("rst_m0_gnt",    m0_gnt,    0);
      check("rst_m0_rvalid", m0_rvalid, 0);
      check("rst_m0_rdata",  m0_rdata,  0);
      check("rst_m1_rvalid", m1_rvalid, 0);
      check("rst_m1_rerr",   m1_rerr,   0);
      step();
      rst = 0; quiet(); settle();
      check("idle_s_req", s_req, 0);
      check("idle_s_addr", s_addr, 0);

      // ---- contention: both hold req 4 cycles with a 1-cycle slave
      for (int i = 0; i < 5; i++) begin
         quiet();
         m0_req = (i < 4); m0_addr = 32'h100;
         m1_req = (i < 4); m1_addr = 32'h200;
         s_rvalid = (i > 0); s_rdata = 64'hA0 + 64'(i) - 64'd1;
         settle();
         check("cont_m0_gnt", m0_gnt, (i < 4) && (i % 2 == 0));
         check("cont_m1_gnt", m1_gnt, (i < 4) && (i % 2 == 1));
         check("cont_s_addr", s_addr, (i >= 4) ? 64'h0 : ((i % 2 == 1) ? 64'h200 : 64'h100));
         check("cont_m0_rvalid", m0_rvalid, (i > 0) && ((i - 1) % 2 == 0));
         check("cont_m1_rvalid", m1_rvalid, (i > 0) && ((i - 1) % 2 == 1));
         if (i > 0 && ((i - 1) % 2 == 0)) check("cont_m0_rdata", m0_rdata, 64'hA0 + 64'(i) - 64'd1);
         if (i > 0 && ((i - 1) % 2 == 1)) check("cont_m1_rdata", m1_rdata, 64'hA0 + 64'(i) - 64'd1);
         step();
      end

      // ---- single master read, 1-cycle slave
      quiet(); m0_req = 1; m0_addr = 32'h4000; settle();
      check("single_m0_gnt", m0_gnt, 1);
      check("single_s_addr", s_addr, 32'h4000);
      check("single_s_wren", s_wren, 0);
      check("single_m1_gnt", m1_gnt, 0);
      check("single_m0_rvalid_c0", m0_rvalid, 0);
      step();
      quiet(); s_rvalid = 1; s_rdata = 64'h1234; settle();
      check("single_m0_rvalid", m0_rvalid, 1);
      check("single_m0_rdata",  m0_rdata,  64'h1234);
      check("single_m0_rerr",   m0_rerr,   0);
      check("single_m1_rvalid", m1_rvalid, 0);
      check("single_m1_rdata",  m1_rdata,  0);
      step();

      // ---- fairness after idle; m1 issues a write
      quiet(); m1_req = 1; m1_wren = 1; m1_addr = 32'h80; m1_wdata = 64'hCAFE_F00D; m1_wstrb = 8'h0F;
      settle();
      check("fair_m1_gnt", m1_gnt, 1);
      check("fair_s_wren", s_wren, 1);
      check("fair_s_wdata", s_wdata, 64'hCAFE_F00D);
      check("fair_s_wstrb", s_wstrb, 8'h0F);
      step();
      quiet(); s_rvalid = 1; settle();
      check("fair_m1_wr_rvalid", m1_rvalid, 1);
      step();
      quiet(); settle();
      check("fair_idle_s_req", s_req, 0);
      step();
      quiet(); m0_req = 1; m1_req = 1; settle();
      check("fair_tie_m0_gnt", m0_gnt, 1);
      check("fair_tie_m1_gnt", m1_gnt, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         quiet(); m0_req = (i < 2); s_rvalid = 1; settle();
         check("fair_m0_rvalid", m0_rvalid, 1);
         check("fair_m0_alone_gnt", m0_gnt, (i < 2));
         step();
      end

      // ---- back-pressure starting from rr_last=1 (set by an m1 transaction)
      quiet(); m1_req = 1; settle();
      check("bp_pre_m1_gnt", m1_gnt, 1);
      step();
      quiet(); s_rvalid = 1; settle();
      check("bp_pre_m1_rvalid", m1_rvalid, 1);
      step();
      for (int i = 0; i < 3; i++) begin
         quiet(); m0_req = 1; m0_addr = 32'h500; s_gnt = 0; settle();
         check("bp_m0_gnt", m0_gnt, 0);
         check("bp_s_req_idle", s_req, 1);
         step();
      end
      quiet(); m0_req = 1; m0_addr = 32'h500; m1_req = 1; settle();
      check("bp_release_m0_gnt", m0_gnt, 1);
      check("bp_release_m1_gnt", m1_gnt, 0);
      step();
      quiet(); m1_req = 1; s_rvalid = 1; settle();
      check("bp_m0_rvalid", m0_rvalid, 1);
      check("bp_m1_gnt", m1_gnt, 1);
      step();
      quiet(); s_rvalid = 1; settle();
      check("bp_m1_rvalid", m1_rvalid, 1);
      step();

      // ---- timeout: m1 granted at cycle 0, slave silent
      quiet(); m1_req = 1; settle();
      check("to_m1_gnt", m1_gnt, 1);
      step();
      for (int c = 1; c < TIMEOUT; c++) begin
         quiet(); m0_req = 1; m0_addr = 32'h300; settle();
         check("to_wait_m1_rvalid", m1_rvalid, 0);
         check("to_wait_m0_gnt", m0_gnt, 0);
         check("to_wait_s_addr", s_addr, 0);
         step();
      end
      quiet(); m0_req = 1; m0_addr = 32'h300; settle();
      check("to_m1_rvalid", m1_rvalid, 1);
      check("to_m1_rerr",   m1_rerr,   1);
      check("to_m1_rdata",  m1_rdata,  0);
      check("to_m0_rvalid", m0_rvalid, 0);
      check("to_overlap_m0_gnt", m0_gnt, 1);
      step();
      quiet(); s_rvalid = 1; s_rdata = 64'h77; settle();
      check("to_m0_rvalid_ok", m0_rvalid, 1);
      check("to_m0_rerr_ok", m0_rerr, 0);
      step();
      quiet(); step(); step();
      quiet(); s_rvalid = 1; s_rdata = 64'h99; settle();
      check("late_m0_rvalid", m0_rvalid, 0);
      check("late_m1_rvalid", m1_rvalid, 0);
      step();

      // ---- reset mid-transaction (rr_last=0 before reset)
      quiet(); m0_req = 1; settle();
      check("rmid_m0_gnt", m0_gnt, 1);
      step();
      quiet(); rst = 1; settle();
      check("rmid_rst_m0_rvalid", m0_rvalid, 0);
      step();
      rst = 0; quiet(); s_rvalid = 1; s_rdata = 64'h55; settle();
      check("rmid_after_m0_rvalid", m0_rvalid, 0);
      check("rmid_after_m0_rdata", m0_rdata, 0);
      check("rmid_after_m1_rvalid", m1_rvalid, 0);
      step();
      quiet(); m0_req = 1; m1_req = 1; settle();
      check("rmid_tie_m0_gnt", m0_gnt, 1);
      check("rmid_tie_m1_gnt", m1_gnt, 0);
      step();
      quiet(); m1_req = 1; s_rvalid = 1; settle();
      check("rmid_m0_rvalid", m0_rvalid, 1);
      check("rmid_m1_gnt", m1_gnt, 1);
      step();
      quiet(); s_rvalid = 1; settle();
      check("rmid_m1_rvalid", m1_rvalid, 1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_periph_arbiter.md
# riscv_periph_arbiter

Two-master, one-slave arbiter for the single-cycle req/gnt/rvalid peripheral bus used by the timer/interrupt and other memory-mapped peripherals. It shares one slave port between the core data port (master 0) and the debug/DMA port (master 1) using round-robin arbitration. It tracks one outstanding transaction at a time and routes the slave response back to the issuing master. A response timeout returns an error response if the slave never answers.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; wstrb width is DATA_W/8
- TIMEOUT, 16, cycles to wait for s_rvalid after a grant; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mN_req  in  1  request from master N (N = 0, 1)
- mN_wren  in  1  write enable
- mN_addr  in  ADDR_W  address
- mN_wdata  in  DATA_W  write data
- mN_wstrb  in  DATA_W/8  byte strobes
- mN_gnt  out  1  request accepted this cycle
- mN_rvalid  out  1  response for master N
- mN_rdata  out  DATA_W  response data
- mN_rerr  out  1  response is a timeout error
- s_req, s_wren, s_addr, s_wdata, s_wstrb  out  per master  forwarded request to the slave
- s_gnt  in  1  slave accepts
- s_rvalid  in  1  slave response
- s_rdata  in  DATA_W  slave read data

## Operation
- State: IDLE, or BUSY with owner (0/1). Also keeps an rr_last pointer (last granted master) and a timeout counter tcnt.
- can_issue = IDLE, or (BUSY and the response completes this cycle, either by s_rvalid or by timeout).
- Winner selection:
  - Only one master requesting: that master wins.
  - Both requesting: the master not equal to rr_last wins.
- s_req = can_issue & (m0_req | m1_req) & !rst. s_wren, s_addr, s_wdata and s_wstrb mux from the winner; they are zero when s_req=0.
- mN_gnt = s_req & s_gnt & (winner==N). Grants are combinational, in the same cycle as the request.
- On an accepted handshake (s_req & s_gnt):
  - state → BUSY, owner ← winner, rr_last ← winner, tcnt ← 0.
- Normal response: BUSY & s_rvalid.
  - m[owner]_rvalid=1, m[owner]_rdata=s_rdata, rerr=0.
  - state → IDLE, unless a new handshake happens in the same cycle, in which case it stays BUSY with the new owner.
- Timeout: BUSY & !s_rvalid & TIMEOUT≠0 & tcnt==TIMEOUT-1.
  - m[owner]_rvalid=1, rdata=0, rerr=1.
  - Same state update as a normal response.
- While BUSY without a response, tcnt increments and saturates at TIMEOUT-1.
- s_rvalid while IDLE (a late response after a timeout) is dropped. No master sees it.
- The non-owner master's rvalid, rdata and rerr are always 0.
- A write gets a response like a read. rdata passes through unchanged; masters ignore it.
- A master that is not granted keeps req asserted with stable address and data until granted. The arbiter does not buffer requests.

## Timing
- Reset state: IDLE, rr_last=1 (so m0 wins the first tie), tcnt=0.
  - While rst=1: all mN_gnt, mN_rvalid, mN_rerr and s_req are 0, and all rdata outputs are 0.
- Reset asserted while BUSY abandons the transaction. No response is delivered, and any later s_rvalid is dropped.
- Grant latency: 0 cycles, when can_issue and s_gnt are true.
- Response latency: the slave's latency. It is combinational from s_rvalid to mN_rvalid, with no added cycle.
- Throughput: one transaction per cycle with a 1-cycle slave, because a response and the next grant overlap in the same cycle.
- With a slave that holds s_gnt=0, no grant occurs and rr_last does not change.
- Timeout response appears exactly TIMEOUT cycles after the grant cycle.

## Test plan
- Single master: m0 reads 0x4000 with a 1-cycle slave returning 0x1234.
  - m0_gnt in cycle 0; m0_rvalid=1, m0_rdata=0x1234, m0_rerr=0 in cycle 1.
  - m1 outputs stay 0 throughout.
- Contention: m0 and m1 both hold req for 4 cycles, 1-cycle slave.
  - Grants alternate m0, m1, m0, m1, one per cycle.
  - Each rvalid goes only to the master granted in the previous cycle.
- Fairness after idle: m1 granted once, bus idle, then both request.
  - m0 wins. Then m0 alone requests twice: m0 is granted both times.
- Timeout: TIMEOUT=16, slave never asserts s_rvalid after m1's grant at cycle 0.
  - m1_rvalid=1, m1_rerr=1, m1_rdata=0 at cycle 16. No grant is possible in cycles 1–15.
  - A late s_rvalid at cycle 20 produces no master rvalid.
- Back-pressure: s_gnt=0 for 3 cycles while m0 requests.
  - m0_gnt=0, state stays IDLE, rr_last unchanged. Grant occurs in the first cycle s_gnt=1.
- Reset mid-transaction: rst pulsed for 1 cycle while BUSY for m0, slave responds the cycle after.
  - No m0_rvalid. After reset, m0 wins the first tie.
